alu_cmd_seq: RTL and testbench

- Operand/command initiator for the 4-bit combinational ALU: the ALU consumes A/B/op and returns a result; this block produces A/B/op from board switches and a push button, and collects the result.
- Sequences operand entry (A, then B, then op) from a 4-bit switch bank and an "enter" button.
- Holds operands stable while the ALU settles, captures the result, and presents a value plus field code for the 7-segment path.
- Supports accumulator chaining: the last result becomes the next A.

---
 rtl/alu_pkg.sv | 33 +++
 rtl/rise_pulse.sv | 20 ++
 rtl/alu_cmd_seq.sv | 182 ++++++++++++++++++
 tb/tb_alu_cmd_seq.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants and encodings for the ALU command sequencer and its bench.
package alu_pkg;

  localparam int unsigned ALU_DW  = 4;
  localparam int unsigned ALU_OPW = 3;
  localparam int unsigned ST_W    = 3;
  localparam int unsigned FLD_W   = 2;

  typedef enum logic [ALU_OPW-1:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_NOT = 3'b010,
    OP_AND = 3'b011,
    OP_OR  = 3'b100,
    OP_XOR = 3'b101,
    OP_LT  = 3'b110,
    OP_EQ  = 3'b111
  } opcode_e;

  typedef enum logic [ST_W-1:0] {
    ST_LOAD_A  = 3'd0,
    ST_LOAD_B  = 3'd1,
    ST_LOAD_OP = 3'd2,
    ST_EXEC    = 3'd3,
    ST_SHOW    = 3'd4
  } state_e;

  localparam logic [FLD_W-1:0] FIELD_A   = 2'd0;
  localparam logic [FLD_W-1:0] FIELD_B   = 2'd1;
  localparam logic [FLD_W-1:0] FIELD_OP  = 2'd2;
  localparam logic [FLD_W-1:0] FIELD_RES = 2'd3;

endpackage

// File: rtl/rise_pulse.sv
// Registered rising-edge detector; previous level resets high so a button
// held through reset yields no pulse until released and pressed again.
module rise_pulse (
  input  logic clk,
  input  logic rst,
  input  logic i_lvl,
  output logic o_pulse_c
);

  logic r_prev;

  // Track the previous level of the input
  always_ff @(posedge clk) begin
    if (rst) r_prev <= 1'b1;
    else     r_prev <= i_lvl;
  end

  assign o_pulse_c = i_lvl & ~r_prev;

endmodule

// File: rtl/alu_cmd_seq.sv
// Operand/command sequencer for a combinational 4-bit ALU: collects A, B and
// opcode from switches, holds them while the ALU settles, captures the result
// and drives the 7-segment value/field, with accumulator chaining.
module alu_cmd_seq
  import alu_pkg::*;
#(
  parameter int unsigned EXEC_WAIT = 1,
  parameter int unsigned DW        = alu_pkg::ALU_DW,
  parameter int unsigned OPW       = alu_pkg::ALU_OPW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [DW-1:0]  sw,
  input  logic           enter,
  input  logic           chain,
  input  logic           clear,
  output logic [DW-1:0]  alu_a,
  output logic [DW-1:0]  alu_b,
  output logic [OPW-1:0] alu_op,
  input  logic [DW-1:0]  alu_res,
  output logic [DW-1:0]  disp_val,
  output logic [1:0]     disp_field,
  output logic           res_valid,
  output logic           busy
);

  localparam int unsigned CW = 4;

  state_e         r_state;
  state_e         w_state_nxt;
  logic [CW-1:0]  r_cnt;
  logic [DW-1:0]  r_a;
  logic [DW-1:0]  r_b;
  logic [OPW-1:0] r_op;
  logic [DW-1:0]  r_res;
  logic           r_res_valid;

  logic w_enter_p;
  logic w_chain_p;
  logic w_ld_a;
  logic w_ld_b;
  logic w_ld_op;
  logic w_chain_ld;
  logic w_cap;
  logic w_rv_clr;

  rise_pulse u_enter_edge (
    .clk       (clk),
    .rst       (rst),
    .i_lvl     (enter),
    .o_pulse_c (w_enter_p)
  );

  rise_pulse u_chain_edge (
    .clk       (clk),
    .rst       (rst),
    .i_lvl     (chain),
    .o_pulse_c (w_chain_p)
  );

  // State register; soft clear returns to operand A entry
  always_ff @(posedge clk) begin
    if (rst || clear) r_state <= ST_LOAD_A;
    else              r_state <= w_state_nxt;
  end

  // Next-state and datapath load strobes; clear discards any same-cycle edge
  always_comb begin
    w_state_nxt = r_state;
    w_ld_a      = 1'b0;
    w_ld_b      = 1'b0;
    w_ld_op     = 1'b0;
    w_chain_ld  = 1'b0;
    w_cap       = 1'b0;
    w_rv_clr    = 1'b0;
    if (!clear) begin
      case (r_state)
        ST_LOAD_A: begin
          if (w_enter_p) begin
            w_state_nxt = ST_LOAD_B;
            w_ld_a      = 1'b1;
            w_rv_clr    = 1'b1;
          end
        end
        ST_LOAD_B: begin
          if (w_enter_p) begin
            w_state_nxt = ST_LOAD_OP;
            w_ld_b      = 1'b1;
            w_rv_clr    = 1'b1;
          end
        end
        ST_LOAD_OP: begin
          if (w_enter_p) begin
            w_state_nxt = ST_EXEC;
            w_ld_op     = 1'b1;
          end
        end
        ST_EXEC: begin
          if (r_cnt == '0) begin
            w_state_nxt = ST_SHOW;
            w_cap       = 1'b1;
          end
        end
        ST_SHOW: begin
          if (w_enter_p) begin
            w_state_nxt = ST_LOAD_A;
            w_rv_clr    = 1'b1;
          end else if (w_chain_p) begin
            w_state_nxt = ST_LOAD_B;
            w_chain_ld  = 1'b1;
          end
        end
        default: w_state_nxt = ST_LOAD_A;
      endcase
    end
  end

  // Operand, wait counter and result registers; only commit/chain edges load
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= '0;
      r_cnt       <= '0;
      r_res       <= '0;
      r_res_valid <= 1'b0;
    end else begin
      if (w_ld_a)          r_a <= sw;
      else if (w_chain_ld) r_a <= r_res;
      if (w_ld_b)          r_b <= sw;
      if (w_ld_op) begin
        r_op  <= sw[OPW-1:0];
        r_cnt <= CW'(EXEC_WAIT - 1);
      end else if (r_state == ST_EXEC && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_cap) r_res <= alu_res;
      if (w_cap)         r_res_valid <= 1'b1;
      else if (w_rv_clr) r_res_valid <= 1'b0;
    end
  end

  // Display selection and busy flag decoded from the current state
  always_comb begin
    disp_val   = sw;
    disp_field = FIELD_A;
    busy       = 1'b0;
    case (r_state)
      ST_LOAD_A: begin
        disp_val   = sw;
        disp_field = FIELD_A;
      end
      ST_LOAD_B: begin
        disp_val   = sw;
        disp_field = FIELD_B;
      end
      ST_LOAD_OP: begin
        disp_val   = DW'(sw[OPW-1:0]);
        disp_field = FIELD_OP;
      end
      ST_EXEC: begin
        disp_val   = r_a;
        disp_field = FIELD_A;
        busy       = 1'b1;
      end
      ST_SHOW: begin
        disp_val   = r_res;
        disp_field = FIELD_RES;
      end
      default: begin
        disp_val   = sw;
        disp_field = FIELD_A;
      end
    endcase
  end

  assign alu_a     = r_a;
  assign alu_b     = r_b;
  assign alu_op    = r_op;
  assign res_valid = r_res_valid;

endmodule

// File: tb/tb_alu_cmd_seq.sv
// Bench for alu_cmd_seq: two instances (EXEC_WAIT=1 and 4) share stimulus;
// results are predicted from a plain ALU model and checked by a monitor.
module tb_alu_cmd_seq;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst, enter, chain, clear;
  logic [3:0] sw;

  logic [3:0] a1, b1, res1, dv1, a4, b4, res4, dv4;
  logic [2:0] op1, op4;
  logic [1:0] df1, df4;
  logic       rv1, bz1, rv4, bz4;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  typedef struct { logic [3:0] res; int cyc; } exp_t;
  exp_t q1[$];
  exp_t q4[$];

  logic [3:0] ea, eb, elast;
  logic [2:0] eop;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                       input logic [2:0] op);
    case (opcode_e'(op))
      OP_ADD: return a + b;
      OP_SUB: return a - b;
      OP_NOT: return ~a;
      OP_AND: return a & b;
      OP_OR:  return a | b;
      OP_XOR: return a ^ b;
      OP_LT:  return (a < b) ? 4'd1 : 4'd0;
      default: return (a == b) ? 4'd1 : 4'd0;
    endcase
  endfunction

  assign res1 = alu_f(a1, b1, op1);
  assign res4 = alu_f(a4, b4, op4);

  alu_cmd_seq #(.EXEC_WAIT(1)) u_dut1 (
    .clk(clk), .rst(rst), .sw(sw), .enter(enter), .chain(chain), .clear(clear),
    .alu_a(a1), .alu_b(b1), .alu_op(op1), .alu_res(res1),
    .disp_val(dv1), .disp_field(df1), .res_valid(rv1), .busy(bz1)
  );

  alu_cmd_seq #(.EXEC_WAIT(4)) u_dut4 (
    .clk(clk), .rst(rst), .sw(sw), .enter(enter), .chain(chain), .clear(clear),
    .alu_a(a4), .alu_b(b4), .alu_op(op4), .alu_res(res4),
    .disp_val(dv4), .disp_field(df4), .res_valid(rv4), .busy(bz4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Scoreboard monitor: each new captured result is popped and compared
  logic pv1 = 1'b0;
  logic pv4 = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rv1 === 1'b1 && pv1 !== 1'b1) begin
      if (q1.size() == 0) begin
        n_chk++;
        $display("FAIL cap1_unexpected: got capture %0h expected none", dv1);
      end else begin
        e = q1.pop_front();
        chk("cap1_res", 32'(dv1), 32'(e.res));
        chk("cap1_field", 32'(df1), 32'(FIELD_RES));
        chk("cap1_busy", 32'(bz1), 0);
        chk("cap1_latency", 32'(cyc - e.cyc), 1);
      end
    end
    if (rv4 === 1'b1 && pv4 !== 1'b1) begin
      if (q4.size() == 0) begin
        n_chk++;
        $display("FAIL cap4_unexpected: got capture %0h expected none", dv4);
      end else begin
        e = q4.pop_front();
        chk("cap4_res", 32'(dv4), 32'(e.res));
        chk("cap4_field", 32'(df4), 32'(FIELD_RES));
        chk("cap4_busy", 32'(bz4), 0);
        chk("cap4_latency", 32'(cyc - e.cyc), 4);
      end
    end
    pv1 = rv1;
    pv4 = rv4;
  end

  task automatic press_enter(input logic [3:0] v);
    sw = v; enter = 1'b1;
    @(negedge clk); enter = 1'b0;
    @(negedge clk);
  endtask

  task automatic press_chain();
    chain = 1'b1;
    @(negedge clk); chain = 1'b0;
    @(negedge clk);
  endtask

  task automatic issue_op(input logic [2:0] op, input bit abort4);
    exp_t e;
    eop   = op;
    e.res = alu_f(ea, eb, op);
    e.cyc = cyc + 1;
    q1.push_back(e);
    if (!abort4) q4.push_back(e);
    elast = e.res;
    press_enter({4'($urandom_range(0, 1)) << 3} | {1'b0, op});
  endtask

  task automatic chk_ops(input string tag);
    chk({tag, "_a1"}, 32'(a1), 32'(ea));
    chk({tag, "_b1"}, 32'(b1), 32'(eb));
    chk({tag, "_op1"}, 32'(op1), 32'(eop));
    chk({tag, "_a4"}, 32'(a4), 32'(ea));
    chk({tag, "_b4"}, 32'(b4), 32'(eb));
    chk({tag, "_op4"}, 32'(op4), 32'(eop));
  endtask

  // Let both instances reach SHOW while toggling switches; operands must hold
  task automatic settle(input string tag);
    for (int k = 0; k < 6; k++) begin
      sw = 4'($urandom);
      @(negedge clk);
      chk_ops(tag);
    end
    chk({tag, "_show_f1"}, 32'(df1), 32'(FIELD_RES));
    chk({tag, "_show_f4"}, 32'(df4), 32'(FIELD_RES));
    chk({tag, "_show_v4"}, 32'(dv4), 32'(elast));
    chk({tag, "_show_rv4"}, 32'(rv4), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bit in_show;
    rst = 1'b1; enter = 1'b1; chain = 1'b0; clear = 1'b0; sw = 4'hA;
    ea = '0; eb = '0; eop = '0; elast = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset values, with enter held high through reset
    chk("rst_a", 32'(a1), 0);
    chk("rst_b", 32'(b1), 0);
    chk("rst_op", 32'(op1), 0);
    chk("rst_rv", 32'(rv1), 0);
    chk("rst_busy", 32'(bz1), 0);
    chk("rst_field", 32'(df1), 32'(FIELD_A));
    chk("rst_dval", 32'(dv1), 32'(sw));
    repeat (10) @(negedge clk);
    chk("held_field1", 32'(df1), 32'(FIELD_A));
    chk("held_field4", 32'(df4), 32'(FIELD_A));
    chk("held_a", 32'(a1), 0);
    enter = 1'b0;
    @(negedge clk);
    press_enter(4'h7);
    chk("held_press_a", 32'(a1), 7);
    chk("held_press_field", 32'(df1), 32'(FIELD_B));
    chk("held_press_b", 32'(b1), 0);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 3 + 5 = 8 with a one-cycle wait
    press_enter(4'h3); ea = 4'h3;
    press_enter(4'h5); eb = 4'h5;
    issue_op(3'(OP_ADD), 1'b0);
    chk("add_rv1", 32'(rv1), 1);
    chk("add_dval1", 32'(dv1), 8);
    chk("add_field1", 32'(df1), 32'(FIELD_RES));
    chk("add_busy1", 32'(bz1), 0);
    chk("add_busy4", 32'(bz4), 1);
    settle("add");

    // Chain: 8 becomes A, then + 1 = 9
    press_chain(); ea = elast;
    chk("chain_a1", 32'(a1), 8);
    chk("chain_a4", 32'(a4), 8);
    chk("chain_field", 32'(df1), 32'(FIELD_B));
    chk("chain_rv_hold", 32'(rv1), 1);
    press_enter(4'h1); eb = 4'h1;
    chk("chain_rv_drop1", 32'(rv1), 0);
    chk("chain_rv_drop4", 32'(rv4), 0);
    issue_op(3'(OP_ADD), 1'b0);
    settle("chain");
    chk("chain_res", 32'(dv1), 9);

    // 2 - 5 = D with operands held while switches toggle
    press_enter(4'($urandom));
    chk("show_exit_field", 32'(df1), 32'(FIELD_A));
    chk("show_exit_rv", 32'(rv1), 0);
    chk("show_exit_a", 32'(a1), 32'(ea));
    press_enter(4'h2); ea = 4'h2;
    press_enter(4'h5); eb = 4'h5;
    issue_op(3'(OP_SUB), 1'b0);
    settle("sub");
    chk("sub_res", 32'(dv1), 32'hD);

    // Enter and chain in the same cycle from SHOW: enter wins
    enter = 1'b1; chain = 1'b1;
    @(negedge clk); enter = 1'b0; chain = 1'b0;
    @(negedge clk);
    chk("both_field1", 32'(df1), 32'(FIELD_A));
    chk("both_field4", 32'(df4), 32'(FIELD_A));
    chk("both_a", 32'(a1), 2);
    chk("both_rv", 32'(rv1), 0);

    // Enter and clear together in LOAD_B: B not loaded, back to LOAD_A
    press_enter(4'h6); ea = 4'h6;
    sw = 4'h9; enter = 1'b1; clear = 1'b1;
    @(negedge clk); enter = 1'b0; clear = 1'b0;
    @(negedge clk);
    ea = '0; eb = '0; eop = '0;
    chk("clr_b1", 32'(b1), 0);
    chk("clr_a1", 32'(a1), 0);
    chk("clr_field1", 32'(df1), 32'(FIELD_A));
    chk("clr_field4", 32'(df4), 32'(FIELD_A));

    // Clear during the long wait aborts the capture on the EXEC_WAIT=4 instance
    press_enter(4'h4); ea = 4'h4;
    press_enter(4'h7); eb = 4'h7;
    issue_op(3'(OP_NOT), 1'b1);
    clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    ea = '0; eb = '0; eop = '0;
    chk("abort_field4", 32'(df4), 32'(FIELD_A));
    chk("abort_busy4", 32'(bz4), 0);
    chk("abort_rv4", 32'(rv4), 0);
    chk("abort_rv1", 32'(rv1), 0);
    chk("abort_dval4", 32'(dv4), 32'(sw));
    chk_ops("abort");
    repeat (6) @(negedge clk);
    chk("abort_idle4", 32'(df4), 32'(FIELD_A));

    // Random transactions, with random chaining from SHOW
    in_show = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (in_show && ($urandom_range(0, 1) == 1)) begin
        press_chain(); ea = elast;
        chk("rnd_chain_a", 32'(a1), 32'(ea));
      end else begin
        if (in_show) press_enter(4'($urandom));
        ea = 4'($urandom);
        press_enter(ea);
      end
      eb = 4'($urandom);
      press_enter(eb);
      issue_op(3'($urandom), 1'b0);
      settle("rnd");
      in_show = 1'b1;
    end

    repeat (2) @(negedge clk);
    chk("q1_drain", 32'(q1.size()), 0);
    chk("q4_drain", 32'(q4.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
